axi4lite_read_ctrl: RTL and testbench

Parametrised AXI4-Lite read-channel slave with a queue of pending read addresses, replacing the earlier negedge-driven single-read handshake with a fully synchronous valid/ready implementation. Accepted read addresses are buffered in an internal FIFO and issued one at a time to a req/ack configuration-register backend with variable latency. Returns backend data on R with an OKAY response, or SLVERR for out-of-range addresses. Sits between the AXI4-Lite interconnect and the FIR configuration/tap register file.

---
 rtl/axi4lite_read_ctrl.sv | 174 +++++++++++++++++
 tb/tb_axi4lite_read_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_read_ctrl.sv
// AXI4-Lite read slave: queues accepted AR addresses and serves them one at a time from a req/ack register backend.
// Optional backend wait timeout when AXIL_RD_TIMEOUT_EN is defined.
module axi4lite_read_ctrl #(
  parameter int                     pADDR_WIDTH = 12,
  parameter int                     pDATA_WIDTH = 32,
  parameter int                     pFIFO_DEPTH = 4,
  parameter logic [pADDR_WIDTH-1:0] pADDR_LIMIT = 'h100,
  parameter int                     pTIMEOUT    = 16
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [1:0]             rresp,
  output logic                   rvalid,
  input  logic                   rready,
  output logic                   cfg_rd_req,
  output logic [pADDR_WIDTH-1:0] cfg_rd_addr,
  input  logic [pDATA_WIDTH-1:0] cfg_rd_data,
  input  logic                   cfg_rd_ack,
  output logic                   busy,
  output logic [1:0]             state_o
);

  localparam int PTR_W = $clog2(pFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [pADDR_WIDTH-1:0] fifo_q [pFIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;
  logic                   rvalid_q, rvalid_d;
  logic                   req_q, req_d;
  logic [pADDR_WIDTH-1:0] addr_q, addr_d;
  logic                   fifo_full, fifo_empty, push, pop;
  logic [pADDR_WIDTH-1:0] head;

`ifdef AXIL_RD_TIMEOUT_EN
  localparam int TMO_W = $clog2(pTIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  assign fifo_full  = (count_q == CNT_W'(pFIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign arready    = !axis_rst && !fifo_full;
  assign push       = arvalid && arready;
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;
  assign head       = fifo_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rvalid_d = rvalid_q;
    req_d    = req_q;
    addr_d   = addr_q;
`ifdef AXIL_RD_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (head < pADDR_LIMIT) begin
            state_d = ST_WAIT;
            req_d   = 1'b1;
            addr_d  = head;
`ifdef AXIL_RD_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end else begin
            // out-of-range reads answer directly without touching the backend
            state_d  = ST_RESP;
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
          end
        end
      end
      ST_WAIT: begin
        if (cfg_rd_ack) begin
          state_d  = ST_RESP;
          rvalid_d = 1'b1;
          rdata_d  = cfg_rd_data;
          rresp_d  = RESP_OKAY;
          req_d    = 1'b0;
        end
`ifdef AXIL_RD_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(pTIMEOUT - 1)) begin
          state_d  = ST_RESP;
          rvalid_d = 1'b1;
          rdata_d  = '0;
          rresp_d  = RESP_SLVERR;
          req_d    = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        if (rready) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
`ifdef AXIL_RD_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rvalid_q <= rvalid_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
`ifdef AXIL_RD_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  // entry storage needs no reset; the pointers and count define validity
  always_ff @(posedge axis_clk) begin
    if (push) fifo_q[wr_ptr_q] <= araddr;
  end

  assign rdata       = rdata_q;
  assign rresp       = rresp_q;
  assign rvalid      = rvalid_q;
  assign cfg_rd_req  = req_q;
  assign cfg_rd_addr = addr_q;
  assign busy        = !fifo_empty || (state_q != ST_IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_axi4lite_read_ctrl.sv
// Self-checking bench for axi4lite_read_ctrl: directed vector table, multi-cycle corner sequences,
// and a randomized run scored against an in-order queue model.
module tb_axi4lite_read_ctrl;

  logic        axis_clk = 1'b0;
  logic        axis_rst;
  logic [11:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        cfg_rd_req;
  logic [11:0] cfg_rd_addr;
  logic [31:0] cfg_rd_data;
  logic        cfg_rd_ack;
  logic        busy;
  logic [1:0]  state_o;

  int total = 0;
  int bad   = 0;

  axi4lite_read_ctrl dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .cfg_rd_req(cfg_rd_req), .cfg_rd_addr(cfg_rd_addr),
    .cfg_rd_data(cfg_rd_data), .cfg_rd_ack(cfg_rd_ack),
    .busy(busy), .state_o(state_o)
  );

  always #5 axis_clk = ~axis_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [11:0] addr;
    int          ack_dly;
    logic [31:0] data;
    int          hold;
    bit          exp_req;
    logic [1:0]  exp_rresp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge axis_clk);
    #1;
  endtask

  function automatic logic [31:0] bdata(input logic [11:0] a);
    return 32'h5A00_0000 ^ ({20'd0, a} * 32'd4099);
  endfunction

  task automatic run_vec(input vec_t v);
    bit stable;
    araddr  = v.addr;
    arvalid = 1'b1;
    check("vec_arready", {31'd0, arready}, 32'd1);
    step;
    arvalid = 1'b0;
    step;
    if (v.exp_req) begin
      check("vec_req_latency", {31'd0, cfg_rd_req}, 32'd1);
      check("vec_req_addr", {20'd0, cfg_rd_addr}, {20'd0, v.addr});
      repeat (v.ack_dly) step;
      cfg_rd_data = v.data;
      cfg_rd_ack  = 1'b1;
      step;
      cfg_rd_ack  = 1'b0;
      cfg_rd_data = '0;
    end else begin
      check("vec_no_req", {31'd0, cfg_rd_req}, 32'd0);
    end
    check("vec_rvalid", {31'd0, rvalid}, 32'd1);
    stable = 1'b1;
    repeat (v.hold) begin
      step;
      if (rvalid !== 1'b1 || rdata !== v.exp_rdata || rresp !== v.exp_rresp || cfg_rd_req !== 1'b0)
        stable = 1'b0;
    end
    check("vec_hold_stable", {31'd0, stable}, 32'd1);
    check("vec_rdata", rdata, v.exp_rdata);
    check("vec_rresp", {30'd0, rresp}, {30'd0, v.exp_rresp});
    rready = 1'b1;
    step;
    rready = 1'b0;
    check("vec_rvalid_drop", {31'd0, rvalid}, 32'd0);
    check("vec_idle", {30'd0, state_o}, 32'd0);
    check("vec_busy", {31'd0, busy}, 32'd0);
  endtask

  logic [11:0] qa [5];
  logic [33:0] exp_q [$];
  logic [11:0] req_q [$];

  initial begin
    int          k_req, k_rsp, cyc, n, dly;
    bit          ok, bk_busy, ar_acc, prev_stall, drive_en;
    logic [11:0] bk_addr;
    logic [31:0] prev_rdata;
    logic [1:0]  prev_rresp;
    logic [33:0] e;

    vecs[0] = '{12'h010, 3, 32'h1234_5678, 2,  1'b1, 2'b00, 32'h1234_5678};
    vecs[1] = '{12'h200, 0, 32'h0,         1,  1'b0, 2'b10, 32'h0};
    vecs[2] = '{12'h0FF, 0, 32'hCAFE_BABE, 10, 1'b1, 2'b00, 32'hCAFE_BABE};
    vecs[3] = '{12'h100, 0, 32'h0,         0,  1'b0, 2'b10, 32'h0};
    vecs[4] = '{12'h000, 5, 32'hFFFF_FFFF, 0,  1'b1, 2'b00, 32'hFFFF_FFFF};
    vecs[5] = '{12'hFFF, 0, 32'h0,         3,  1'b0, 2'b10, 32'h0};

    axis_rst = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    cfg_rd_data = '0; cfg_rd_ack = 1'b0;
    step;
    step;
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_req", {31'd0, cfg_rd_req}, 32'd0);
    check("rst_addr", {20'd0, cfg_rd_addr}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rresp", {30'd0, rresp}, 32'd0);
    check("rst_state", {30'd0, state_o}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    axis_rst = 1'b0;
    step;
    check("post_rst_arready", {31'd0, arready}, 32'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // queue fill with R backpressure
    qa[0] = 12'h020; qa[1] = 12'h024; qa[2] = 12'h028; qa[3] = 12'h02C; qa[4] = 12'h030;
    for (int i = 0; i < 5; i++) begin
      araddr  = qa[i];
      arvalid = 1'b1;
      check("fill_arready", {31'd0, arready}, 32'd1);
      step;
    end
    arvalid = 1'b0;
    check("fill_full_arready", {31'd0, arready}, 32'd0);
    check("fill_busy", {31'd0, busy}, 32'd1);
    check("fill_req_addr0", {20'd0, cfg_rd_addr}, {20'd0, qa[0]});
    cfg_rd_data = bdata(qa[0]);
    cfg_rd_ack  = 1'b1;
    step;
    cfg_rd_ack = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      step;
      if (cfg_rd_req !== 1'b0 || arready !== 1'b0 || rvalid !== 1'b1) ok = 1'b0;
    end
    check("fill_backpressure", {31'd0, ok}, 32'd1);
    rready = 1'b1;
    k_req = 1; k_rsp = 0; cyc = 0;
    while (k_rsp < 5 && cyc < 200) begin
      cfg_rd_ack = 1'b0;
      if (rvalid) begin
        check("fill_rdata", rdata, bdata(qa[k_rsp]));
        check("fill_rresp", {30'd0, rresp}, 32'd0);
        k_rsp++;
      end
      if (cfg_rd_req) begin
        if (k_req < 5) begin
          check("fill_req_addr", {20'd0, cfg_rd_addr}, {20'd0, qa[k_req]});
          cfg_rd_data = bdata(qa[k_req]);
          k_req++;
        end
        cfg_rd_ack = 1'b1;
      end
      step;
      cyc++;
    end
    cfg_rd_ack = 1'b0;
    rready = 1'b0;
    check("fill_resp_count", k_rsp, 32'd5);
    check("fill_req_count", k_req, 32'd5);
    check("fill_done_arready", {31'd0, arready}, 32'd1);
    check("fill_done_busy", {31'd0, busy}, 32'd0);

    // reset mid-WAIT with two addresses still queued
    for (int i = 0; i < 3; i++) begin
      araddr  = 12'h040 + 12'(4 * i);
      arvalid = 1'b1;
      step;
    end
    arvalid = 1'b0;
    check("rstw_req", {31'd0, cfg_rd_req}, 32'd1);
    axis_rst = 1'b1;
    #1;
    check("rstw_arready_low", {31'd0, arready}, 32'd0);
    step;
    axis_rst = 1'b0;
    check("rstw_state", {30'd0, state_o}, 32'd0);
    check("rstw_busy", {31'd0, busy}, 32'd0);
    check("rstw_rvalid", {31'd0, rvalid}, 32'd0);
    check("rstw_req_low", {31'd0, cfg_rd_req}, 32'd0);
    cfg_rd_data = 32'hDEAD_BEEF;
    cfg_rd_ack  = 1'b1;
    step;
    cfg_rd_ack = 1'b0;
    ok = 1'b1;
    repeat (6) begin
      step;
      if (rvalid !== 1'b0 || cfg_rd_req !== 1'b0 || state_o !== 2'd0) ok = 1'b0;
    end
    check("rstw_late_ack_ignored", {31'd0, ok}, 32'd1);

    // backend never acknowledges
    araddr  = 12'h050;
    arvalid = 1'b1;
    step;
    arvalid = 1'b0;
    step;
    check("tmo_req", {31'd0, cfg_rd_req}, 32'd1);
`ifdef AXIL_RD_TIMEOUT_EN
    n = 0;
    while (rvalid !== 1'b1 && n < 40) begin
      step;
      n++;
    end
    check("tmo_wait_cycles", n, 32'd16);
    check("tmo_rresp", {30'd0, rresp}, 32'd2);
    check("tmo_rdata", rdata, 32'd0);
    check("tmo_req_drop", {31'd0, cfg_rd_req}, 32'd0);
    cfg_rd_data = 32'h1111_2222;
    cfg_rd_ack  = 1'b1;
    step;
    cfg_rd_ack = 1'b0;
    check("tmo_late_ack_rdata", rdata, 32'd0);
    check("tmo_late_ack_rresp", {30'd0, rresp}, 32'd2);
`else
    ok = 1'b1;
    repeat (40) begin
      step;
      if (state_o !== 2'd1 || cfg_rd_req !== 1'b1 || rvalid !== 1'b0) ok = 1'b0;
    end
    check("notmo_wait_persists", {31'd0, ok}, 32'd1);
    cfg_rd_data = 32'h7777_0001;
    cfg_rd_ack  = 1'b1;
    step;
    cfg_rd_ack = 1'b0;
    check("notmo_rdata", rdata, 32'h7777_0001);
`endif
    rready = 1'b1;
    step;
    rready = 1'b0;
    check("tmo_idle", {30'd0, state_o}, 32'd0);

    // randomized traffic against an in-order queue model
    bk_busy = 1'b0; ar_acc = 1'b0; prev_stall = 1'b0; drive_en = 1'b1;
    dly = 0; bk_addr = '0; prev_rdata = '0; prev_rresp = '0;
    cyc = 0;
    while (cyc < 6000 && (drive_en || exp_q.size() != 0 || arvalid)) begin
      if (cyc == 3000) drive_en = 1'b0;
      rready = ($urandom_range(0, 3) != 0);
      if (prev_stall) begin
        check("rnd_rvalid_hold", {31'd0, rvalid}, 32'd1);
        check("rnd_rdata_stable", rdata, prev_rdata);
        check("rnd_rresp_stable", {30'd0, rresp}, {30'd0, prev_rresp});
      end
      prev_stall = 1'b0;
      if (rvalid) begin
        if (rready) begin
          if (exp_q.size() == 0) begin
            check("rnd_unexpected_resp", {31'd0, rvalid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("rnd_rdata", rdata, e[31:0]);
            check("rnd_rresp", {30'd0, rresp}, {30'd0, e[33:32]});
          end
        end else begin
          prev_stall = 1'b1;
          prev_rdata = rdata;
          prev_rresp = rresp;
        end
      end
      if (cfg_rd_req && !bk_busy) begin
        bk_busy = 1'b1;
        dly = $urandom_range(0, 6);
        if (req_q.size() == 0) begin
          check("rnd_unexpected_req", {31'd0, cfg_rd_req}, 32'd0);
          bk_addr = cfg_rd_addr;
        end else begin
          bk_addr = req_q.pop_front();
          check("rnd_req_addr", {20'd0, cfg_rd_addr}, {20'd0, bk_addr});
        end
      end
      if (bk_busy) begin
        check("rnd_req_hold", {31'd0, cfg_rd_req}, 32'd1);
        if (dly == 0) begin
          cfg_rd_ack  = 1'b1;
          cfg_rd_data = bdata(bk_addr);
          bk_busy = 1'b0;
        end else begin
          cfg_rd_ack = 1'b0;
          dly--;
        end
      end else begin
        cfg_rd_ack  = ($urandom_range(0, 7) == 0);
        cfg_rd_data = $urandom;
      end
      if (ar_acc) arvalid = 1'b0;
      ar_acc = 1'b0;
      if (!arvalid && drive_en && $urandom_range(0, 2) == 0) begin
        arvalid = 1'b1;
        araddr  = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(256, 4095))
                                               : 12'($urandom_range(0, 255));
      end
      if (arvalid && arready) begin
        ar_acc = 1'b1;
        if (araddr < 12'h100) begin
          exp_q.push_back({2'b00, bdata(araddr)});
          req_q.push_back(araddr);
        end else begin
          exp_q.push_back({2'b10, 32'h0});
        end
      end
      step;
      cyc++;
    end
    cfg_rd_ack = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    step;
    check("rnd_drained", exp_q.size(), 32'd0);
    check("rnd_req_drained", req_q.size(), 32'd0);
    check("rnd_busy_end", {31'd0, busy}, 32'd0);
    check("rnd_state_end", {30'd0, state_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
